// File: rtl/pp_pipeline_accel_fifo_arb.sv
// Four-requester round-robin arbiter that feeds one shared FIFO. Each grant is
// a burst of up to BURST_MAX beats, and the FIFO word is tagged with the source id.
module pp_pipeline_accel_fifo_arb #(
    parameter int DATA_WIDTH = 5,
    parameter int BURST_MAX  = 4
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      arb_en,
    input  logic [3:0]                req_write,
    input  logic [4*DATA_WIDTH-1:0]   req_din,
    output logic [3:0]                req_full_n,
    input  logic                      fifo_full_n,
    output logic                      fifo_write,
    output logic [DATA_WIDTH+1:0]     fifo_din,
    output logic                      grant_valid,
    output logic [1:0]                grant_id
);

    localparam logic [3:0] LAST_BEAT = 4'(BURST_MAX - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                       state, state_nxt;
    logic [1:0]                   last_id;
    logic [3:0]                   beat_cnt;
    logic [1:0]                   sel, cand;
    logic                         found;
    logic                         accept, burst_done;
    logic [3:0][DATA_WIDTH-1:0]   din_arr;

    assign din_arr = req_din;

    // Scan starts one past the last winner, so a steady requester waits at most 3 grants.
    always_comb begin
        sel   = 2'd0;
        cand  = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_id + 2'(k);
            if (!found && req_write[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    assign accept     = (state == GRANT) && req_write[grant_id] && fifo_full_n;
    assign burst_done = accept && (beat_cnt == LAST_BEAT);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state    <= IDLE;
            grant_id <= 2'd0;
            last_id  <= 2'd3;
            beat_cnt <= 4'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == GRANT) begin
                grant_id <= sel;
                beat_cnt <= 4'd0;
            end
            if (accept)
                beat_cnt <= beat_cnt + 4'd1;
            if (state == GRANT && state_nxt == IDLE)
                last_id <= grant_id;
        end
    end

    // A dropped request ends the burst early. A full FIFO only stalls it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_en && found) state_nxt = GRANT;
            GRANT:   if (!req_write[grant_id] || burst_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_full_n  = 4'b0000;
        fifo_write  = 1'b0;
        fifo_din    = '0;
        grant_valid = 1'b0;
        if (state == GRANT) begin
            grant_valid          = 1'b1;
            fifo_write           = req_write[grant_id];
            fifo_din             = {grant_id, din_arr[grant_id]};
            req_full_n[grant_id] = fifo_full_n;
        end
    end

endmodule

// File: tb/tb_pp_pipeline_accel_fifo_arb.sv
// Directed bench for the burst arbiter. A scoreboard checks every FIFO write and
// cycle checks cover grant order, stall, arb_en gating, reset, and BURST_MAX=1.
module tb_pp_pipeline_accel_fifo_arb;

    localparam int DW = 5;

    logic            ap_clk, ap_rst_n, arb_en, fifo_full_n;
    logic [3:0]      req_write, req_write_b;
    logic [4*DW-1:0] req_din;
    logic [3:0]      req_full_n, req_full_n_b;
    logic            fifo_write, fifo_write_b;
    logic [DW+1:0]   fifo_din, fifo_din_b;
    logic            grant_valid, grant_valid_b;
    logic [1:0]      grant_id, grant_id_b;

    logic [DW+1:0]   sb[$];
    int              n_cmp = 0;
    int              n_err = 0;

    pp_pipeline_accel_fifo_arb #(.DATA_WIDTH(DW), .BURST_MAX(4)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .arb_en(arb_en),
        .req_write(req_write), .req_din(req_din), .req_full_n(req_full_n),
        .fifo_full_n(fifo_full_n), .fifo_write(fifo_write), .fifo_din(fifo_din),
        .grant_valid(grant_valid), .grant_id(grant_id)
    );

    pp_pipeline_accel_fifo_arb #(.DATA_WIDTH(DW), .BURST_MAX(1)) dut_b (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .arb_en(arb_en),
        .req_write(req_write_b), .req_din(req_din), .req_full_n(req_full_n_b),
        .fifo_full_n(fifo_full_n), .fifo_write(fifo_write_b), .fifo_din(fifo_din_b),
        .grant_valid(grant_valid_b), .grant_id(grant_id_b)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    function automatic logic [DW-1:0] dat(input int id);
        case (id)
            0:       dat = 5'd3;
            1:       dat = 5'd10;
            2:       dat = 5'd17;
            default: dat = 5'd24;
        endcase
    endfunction

    function automatic logic [DW+1:0] word(input int id);
        logic [1:0] i2;
        i2 = 2'(id);
        word = {i2, dat(id)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic push(input int id, input int n);
        for (int i = 0; i < n; i++) sb.push_back(word(id));
    endtask

    // Monitor: every accepted beat must match the oldest expected word.
    initial begin
        forever begin
            @(negedge ap_clk);
            if (fifo_write && fifo_full_n) begin
                if (sb.size() == 0)
                    chk("sb_unexpected_write", {25'd0, fifo_din}, 32'hffff_ffff);
                else
                    chk("sb_beat", {25'd0, fifo_din}, {25'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        ap_rst_n    = 1'b1;
        arb_en      = 1'b1;
        fifo_full_n = 1'b1;
        req_write   = 4'b1111;
        req_write_b = 4'b0000;
        req_din     = {dat(3), dat(2), dat(1), dat(0)};
        #1 ap_rst_n = 1'b0;

        // reset state
        @(negedge ap_clk);
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_fifo_write", fifo_write, 0);
        chk("rst_req_full_n", req_full_n, 0);
        chk("rst_grant_id", grant_id, 0);
        cyc();

        // all requesting: grants 0,1,2,3,0 with 4 beats and one idle cycle each
        for (int g = 0; g < 5; g++) push(g % 4, 4);
        ap_rst_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge ap_clk);
            chk("rr_grant_valid", grant_valid, (k % 5) != 0);
            if (k % 5 != 0) chk("rr_grant_id", grant_id, (k / 5) % 4);
            cyc();
        end
        req_write = 4'b0000;
        cyc();
        cyc();
        chk("rr_sb_drained", sb.size(), 0);

        // single requester 2, two beats, then released
        push(2, 2);
        req_write = 4'b0100;
        @(negedge ap_clk); chk("r2_idle", grant_valid, 0);
        cyc();
        @(negedge ap_clk); chk("r2_grant_id", grant_id, 2); chk("r2_full_n", req_full_n, 4'b0100);
        cyc();
        cyc();
        req_write = 4'b0000;
        @(negedge ap_clk); chk("r2_release_fw", fifo_write, 0); chk("r2_release_gv", grant_valid, 1);
        cyc();
        @(negedge ap_clk); chk("r2_back_idle", grant_valid, 0); chk("r2_sb_drained", sb.size(), 0);

        // last_id is now 2, so requesters {1,3} must pick 3
        push(3, 1);
        req_write = 4'b1010;
        cyc();
        @(negedge ap_clk); chk("last_id_pick", grant_id, 3);
        cyc();
        req_write = 4'b0000;
        cyc();
        @(negedge ap_clk); chk("r3_sb_drained", sb.size(), 0);

        // stall: grant 1, FIFO full for 5 cycles after two beats
        push(1, 4);
        req_write = 4'b0010;
        cyc();
        @(negedge ap_clk); chk("st_grant_id", grant_id, 1); chk("st_full_n", req_full_n, 4'b0010);
        cyc();
        cyc();
        fifo_full_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge ap_clk);
            chk("st_fifo_write", fifo_write, 1);
            chk("st_req_full_n", req_full_n, 4'b0000);
            chk("st_grant_valid", grant_valid, 1);
            cyc();
        end
        fifo_full_n = 1'b1;
        cyc();
        cyc();
        req_write = 4'b0000;
        @(negedge ap_clk); chk("st_done_idle", grant_valid, 0); chk("st_sb_drained", sb.size(), 0);
        cyc();

        // arb_en dropped mid-burst: burst finishes, no new grant until re-enabled
        push(2, 4);
        req_write = 4'b1111;
        cyc();
        @(negedge ap_clk); chk("ae_grant_id", grant_id, 2);
        cyc();
        arb_en = 1'b0;
        cyc();
        cyc();
        @(negedge ap_clk); chk("ae_last_beat_gv", grant_valid, 1);
        cyc();
        for (int k = 0; k < 3; k++) begin
            @(negedge ap_clk); chk("ae_blocked", grant_valid, 0);
            cyc();
        end
        arb_en = 1'b1;
        push(3, 1);
        cyc();
        @(negedge ap_clk); chk("ae_regrant_id", grant_id, 3);
        cyc();
        req_write = 4'b0000;
        @(negedge ap_clk); chk("ae_release_fw", fifo_write, 0);
        cyc();
        @(negedge ap_clk); chk("ae_sb_drained", sb.size(), 0);

        // asynchronous reset during beat 3 of a burst to requester 0
        push(0, 2);
        req_write = 4'b1111;
        cyc();
        cyc();
        cyc();
        #2 ap_rst_n = 1'b0;
        #1;
        chk("ar_grant_valid", grant_valid, 0);
        chk("ar_fifo_write", fifo_write, 0);
        chk("ar_req_full_n", req_full_n, 0);
        chk("ar_grant_id", grant_id, 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge ap_clk); chk("ar_hold_fw", fifo_write, 0);
            cyc();
        end
        ap_rst_n = 1'b1;
        push(0, 1);
        cyc();
        @(negedge ap_clk); chk("ar_first_id", grant_id, 0); chk("ar_first_gv", grant_valid, 1);
        cyc();
        req_write = 4'b0000;
        cyc();
        cyc();
        chk("ar_sb_drained", sb.size(), 0);

        // BURST_MAX=1 instance: alternating 0,3,0,3 one beat each
        req_write_b = 4'b1001;
        for (int k = 0; k < 8; k++) begin
            @(negedge ap_clk);
            chk("b1_grant_valid", grant_valid_b, k % 2);
            if (k % 2 == 1) begin
                chk("b1_grant_id", grant_id_b, (k % 4 == 1) ? 0 : 3);
                chk("b1_fifo_write", fifo_write_b, 1);
                chk("b1_fifo_din", fifo_din_b, word((k % 4 == 1) ? 0 : 3));
            end
            cyc();
        end
        req_write_b = 4'b0000;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pp_pipeline_accel_fifo_arb.md
PP_PIPELINE_ACCEL_FIFO_ARB -- requirements
Module: pp_pipeline_accel_fifo_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 5, SHALL set the requester payload width.
REQ-002 Parameter BURST_MAX, default 4, range 1..16, SHALL set the maximum beats per grant.
REQ-003 Parameter NUM_REQ SHALL be fixed at 4; ID width 2.
REQ-004 ap_clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 ap_rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 arb_en  in  1  SHALL permit new grants when 1.
REQ-007 req_write  in  4  SHALL carry the per-requester write request, bit i = requester i.
REQ-008 req_din  in  4*DATA_WIDTH  SHALL carry the per-requester payload, slice i = requester i.
REQ-009 req_full_n  out  4  SHALL be the per-requester ready; 1 = beat accepted if req_write set.
REQ-010 fifo_full_n  in  1  SHALL be the shared FIFO's not-full flag.
REQ-011 fifo_write  out  1  SHALL be the shared FIFO write strobe.
REQ-012 fifo_din  out  DATA_WIDTH+2  SHALL be {grant_id, req_din slice of granted requester}.
REQ-013 grant_valid  out  1  SHALL be 1 while in state GRANT.
REQ-014 grant_id  out  2  SHALL be the currently or most recently granted requester.

Function
REQ-015 States SHALL be IDLE and GRANT; registers: state, grant_id, last_id (2b), beat_cnt (4b).
REQ-016 IDLE: if arb_en=1 and req_write!=0, SHALL select the first set bit scanning last_id+1, last_id+2, ... (mod 4), load grant_id, clear beat_cnt, enter GRANT next cycle.
REQ-017 IDLE: fifo_write=0, req_full_n=0 for all bits, grant_valid=0.
REQ-018 GRANT: fifo_write SHALL equal req_write[grant_id] (combinational); fifo_din SHALL be {grant_id, slice grant_id}.
REQ-019 GRANT: req_full_n[grant_id] SHALL equal fifo_full_n; all other bits 0.
REQ-020 A beat SHALL be accepted iff state=GRANT and req_write[grant_id]=1 and fifo_full_n=1; beat_cnt increments on each accepted beat.
REQ-021 GRANT -> IDLE SHALL occur on an accepted beat with beat_cnt=BURST_MAX-1 (burst complete).
REQ-022 GRANT -> IDLE SHALL occur in any cycle with req_write[grant_id]=0 (requester released).
REQ-023 fifo_full_n=0 with req_write[grant_id]=1 SHALL hold GRANT with beat_cnt unchanged (stall; no timeout).
REQ-024 On every GRANT -> IDLE transition, last_id SHALL load grant_id.
REQ-025 Arbitration latency SHALL be 1 cycle IDLE per grant; maximum throughput BURST_MAX beats per BURST_MAX+1 cycles.
REQ-026 arb_en=0 during GRANT SHALL NOT abort the burst; it blocks only the next IDLE selection.
REQ-027 Requests of non-granted requesters SHALL be ignored and never acknowledged; they are not latched.
REQ-028 Round-robin SHALL guarantee any continuously requesting requester a grant within 4 grants.
REQ-029 BURST_MAX=1 SHALL release after every accepted beat.

Reset
REQ-030 ap_rst_n=0 SHALL immediately force state=IDLE, grant_id=0, last_id=3, beat_cnt=0, independent of ap_clk.
REQ-031 During and after reset, until the first grant: fifo_write=0, req_full_n=4'b0000, grant_valid=0, grant_id=0.
REQ-032 Reset asserted mid-burst SHALL discard the burst; the in-flight beat in that cycle SHALL NOT be written (fifo_write=0 while ap_rst_n=0).
REQ-033 Deassertion SHALL take effect at the next rising edge; the first grant after reset goes to the lowest-index requesting bit.

Verification
REQ-034 Reset, arb_en=1, req_write=4'b1111 continuously, fifo_full_n=1, BURST_MAX=4 -> grants 0,1,2,3,0; 4 beats each; fifo_din[6:5] matches; one idle cycle between grants.
REQ-035 req_write=4'b0100 only, hold 2 beats then drop -> grant_id=2, 2 beats written, IDLE next cycle, last_id=2.
REQ-036 Granted to 1, fifo_full_n=0 for 5 cycles mid-burst -> fifo_write=1, req_full_n=4'b0000, beat_cnt frozen; burst completes with exactly 4 beats after fifo_full_n=1.
REQ-037 arb_en=0 mid-burst with all requesting -> burst finishes, then IDLE with no new grant until arb_en=1.
REQ-038 ap_rst_n pulsed low asynchronously after beat 2 of a burst -> outputs zero immediately, no further fifo_write; after release requester 0 granted first.
REQ-039 BURST_MAX=1, req_write=4'b1001 -> alternating grants 0,3,0,3, one beat each.
